// File: rtl/scanline_pkg.sv
// Shared scanline-effect definitions: darkening modes used by the effect
// pipeline and by the OSD/config decode.
package scanline_pkg;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    D25 = 2'd1,
    D50 = 2'd2,
    D75 = 2'd3
  } mode_e;

endpackage

// File: rtl/scanline_fx_if.sv
// Video stream bundle around the scanline effect: controls, syncs and colour in,
// delay-matched syncs and processed colour out.
interface scanline_fx_if #(
  parameter int DW = 8
);

  logic          pix_ce;
  logic [1:0]    mode;
  logic          hs;
  logic          vs;
  logic          blank;
  logic [DW-1:0] red;
  logic [DW-1:0] green;
  logic [DW-1:0] blue;
  logic [DW-1:0] red_out;
  logic [DW-1:0] green_out;
  logic [DW-1:0] blue_out;
  logic          hs_out;
  logic          vs_out;
  logic          blank_out;

  modport master (
    output pix_ce, mode, hs, vs, blank, red, green, blue,
    input  red_out, green_out, blue_out, hs_out, vs_out, blank_out
  );

  modport slave (
    input  pix_ce, mode, hs, vs, blank, red, green, blue,
    output red_out, green_out, blue_out, hs_out, vs_out, blank_out
  );

endinterface

// File: rtl/scanline_fx.sv
// Scanline darkening: odd lines of each frame are dimmed by the mode latched at
// the last vsync edge; one pix_ce of latency on colour and syncs alike.
module scanline_fx
  import scanline_pkg::*;
#(
  parameter int DW = 8
) (
  input logic         clk,
  input logic         reset,
  scanline_fx_if.slave vid
);

  logic  hs_d;
  logic  vs_d;
  logic  parity;
  mode_e mode_act;
  logic  hs_rise;
  logic  vs_rise;

  assign hs_rise = vid.hs & ~hs_d;
  assign vs_rise = vid.vs & ~vs_d;

  // c - (c>>2) never underflows because c>>2 <= c.
  function automatic logic [DW-1:0] darken(input logic [DW-1:0] c,
                                           input mode_e         m,
                                           input logic          odd);
    logic [DW-1:0] r;
    r = c;
    if (odd) begin
      case (m)
        D25:     r = c - (c >> 2);
        D50:     r = c >> 1;
        D75:     r = c >> 2;
        default: r = c;
      endcase
    end
    return r;
  endfunction

  // Output stage: parity and mode_act below are the pre-update values, so a
  // toggle on this edge only affects the next pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      parity    <= 1'b0;
      mode_act  <= OFF;
      vid.red_out   <= '0;
      vid.green_out <= '0;
      vid.blue_out  <= '0;
      vid.hs_out    <= 1'b0;
      vid.vs_out    <= 1'b0;
      vid.blank_out <= 1'b0;
    end else if (vid.pix_ce) begin
      hs_d <= vid.hs;
      vs_d <= vid.vs;
      if (vs_rise) begin
        parity   <= 1'b0;
        mode_act <= mode_e'(vid.mode);
      end else if (hs_rise) begin
        parity <= ~parity;
      end
      vid.red_out   <= vid.blank ? '0 : darken(vid.red,   mode_act, parity);
      vid.green_out <= vid.blank ? '0 : darken(vid.green, mode_act, parity);
      vid.blue_out  <= vid.blank ? '0 : darken(vid.blue,  mode_act, parity);
      vid.hs_out    <= vid.hs;
      vid.vs_out    <= vid.vs;
      vid.blank_out <= vid.blank;
    end
  end

endmodule

// File: tb/tb_scanline_fx.sv
// Scoreboard bench for scanline_fx: directed pixels push hand-computed results,
// a negedge monitor pops on every accepted pixel and checks hold/reset otherwise.
module tb_scanline_fx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scanline_fx_if #(.DW(8)) vif ();

  scanline_fx #(.DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vif)
  );

  // {r, g, b, hs, vs, blank}
  logic [26:0] exp_q[$];
  logic [26:0] cur_exp = '0;
  logic        have_exp = 1'b0;
  logic        ce_q = 1'b0;
  logic        rst_q = 1'b0;

  always @(posedge clk) begin
    ce_q  <= vif.pix_ce & ~reset;
    rst_q <= reset;
  end

  function automatic logic [26:0] actual();
    return {vif.red_out, vif.green_out, vif.blue_out,
            vif.hs_out, vif.vs_out, vif.blank_out};
  endfunction

  task automatic compare(input string name);
    checks++;
    if (actual() !== cur_exp) begin
      errors++;
      $display("FAIL %s at %0t: got rgb=%0d,%0d,%0d hs/vs/blank=%b%b%b expected rgb=%0d,%0d,%0d hs/vs/blank=%b%b%b",
               name, $time, vif.red_out, vif.green_out, vif.blue_out,
               vif.hs_out, vif.vs_out, vif.blank_out,
               cur_exp[26:19], cur_exp[18:11], cur_exp[10:3],
               cur_exp[2], cur_exp[1], cur_exp[0]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_q) begin
      cur_exp  = '0;
      have_exp = 1'b1;
      compare("reset_state");
    end else if (ce_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow at %0t: output with no expected entry", $time);
      end else begin
        cur_exp  = exp_q.pop_front();
        have_exp = 1'b1;
        compare("pixel");
      end
    end else if (have_exp) begin
      compare("hold");
    end
  end

  task automatic px(input logic h, input logic v, input logic bl,
                    input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    @(negedge clk);
    vif.pix_ce = 1'b1;
    vif.hs     = h;
    vif.vs     = v;
    vif.blank  = bl;
    vif.red    = r;
    vif.green  = g;
    vif.blue   = b;
    exp_q.push_back({er, eg, eb, h, v, bl});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vif.pix_ce = 1'b0;
      vif.hs     = 1'b1;
      vif.vs     = 1'b1;
      vif.blank  = 1'b0;
      vif.red    = 8'(8'h11 + i);
      vif.green  = 8'h22;
      vif.blue   = 8'h33;
    end
  endtask

  task automatic pulse_reset(input logic h, input logic v);
    @(negedge clk);
    reset      = 1'b1;
    vif.pix_ce = 1'b1;
    vif.hs     = h;
    vif.vs     = v;
    vif.blank  = 1'b0;
    vif.red    = 8'hff;
    vif.green  = 8'hff;
    vif.blue   = 8'hff;
    @(negedge clk);
    reset      = 1'b0;
    vif.pix_ce = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.pix_ce = 1'b0;
    vif.mode   = 2'd2;
    vif.hs     = 1'b0;
    vif.vs     = 1'b0;
    vif.blank  = 1'b0;
    vif.red    = '0;
    vif.green  = '0;
    vif.blue   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 50% on odd lines, constant 255,128,0
    px(0, 1, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 255, 128, 0, 255, 128, 0);
    px(1, 0, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 255, 128, 0, 127, 64, 0);
    px(0, 0, 0, 255, 128, 0, 127, 64, 0);
    px(1, 0, 0, 255, 128, 0, 127, 64, 0);
    px(0, 0, 0, 255, 128, 0, 255, 128, 0);

    // mode change mid-frame stays at 50% until vsync; pix_ce gap mid-line
    vif.mode = 2'd3;
    px(1, 0, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 255, 128, 0, 127, 64, 0);
    idle(5);
    px(0, 0, 0, 255, 128, 0, 127, 64, 0);

    // hs and vs together on an odd line: parity cleared, then 75%
    px(1, 1, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 255, 128, 0, 255, 128, 0);
    px(1, 0, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 255, 128, 0, 63, 32, 0);

    // 25% with truncation, and blanking on an odd line
    vif.mode = 2'd1;
    px(0, 1, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 255, 255, 255, 255, 255, 255);
    px(1, 0, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 255, 128, 0, 192, 96, 0);
    px(0, 0, 0, 100, 3, 1, 75, 3, 1);
    px(0, 0, 1, 255, 255, 255, 0, 0, 0);

    // reset mid-line during 75%: pass-through until the next vsync
    vif.mode = 2'd3;
    px(0, 1, 1, 0, 0, 0, 0, 0, 0);
    px(1, 0, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 255, 128, 0, 63, 32, 0);
    pulse_reset(0, 0);
    px(0, 0, 0, 255, 128, 0, 255, 128, 0);
    px(1, 0, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 255, 128, 0, 255, 128, 0);
    px(0, 1, 1, 0, 0, 0, 0, 0, 0);
    px(1, 0, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 255, 128, 0, 63, 32, 0);

    // vs already high at reset release counts as a rising edge
    vif.mode = 2'd2;
    pulse_reset(0, 1);
    px(0, 1, 1, 0, 0, 0, 0, 0, 0);
    px(1, 0, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 0, 255, 128, 1, 127, 64, 0);

    @(negedge clk);
    vif.pix_ce = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scanline_fx.md
SCANLINE_FX -- requirements
Module: scanline_fx

Interface
REQ-001 SHALL have parameter DW, default 8, meaning bits per colour channel.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port pix_ce  input  1  pixel clock enable; state advances only on clk edges where pix_ce=1.
REQ-005 SHALL have port mode  input  2  requested darkening: 0 off, 1 = 25%, 2 = 50%, 3 = 75%.
REQ-006 SHALL have port hs  input  1  horizontal sync, active-high.
REQ-007 SHALL have port vs  input  1  vertical sync, active-high.
REQ-008 SHALL have port blank  input  1  blanking, active-high.
REQ-009 SHALL have ports red, green, blue  input  DW each  pixel colour from the horizontal blend stage.
REQ-010 SHALL have ports red_out, green_out, blue_out  output  DW each  processed colour.
REQ-011 SHALL have ports hs_out, vs_out, blank_out  output  1 each  syncs and blank, delay-matched to colour.

Function
REQ-012 SHALL register hs and vs on every pix_ce as hs_d and vs_d for edge detection.
REQ-013 SHALL define an hs rising edge as hs=1 and hs_d=0, and a vs rising edge as vs=1 and vs_d=0, both sampled on pix_ce.
REQ-014 SHALL toggle the 1-bit line parity on each hs rising edge.
REQ-015 SHALL clear parity to 0 on a vs rising edge; when both edges occur in the same pix_ce, the vs edge wins and parity = 0.
REQ-016 SHALL latch mode into mode_act only on a vs rising edge, so any mid-frame mode change takes effect at the next frame.
REQ-017 SHALL pass colour unchanged when parity=0 or mode_act=0.
REQ-018 SHALL produce, when parity=1 and mode_act=1, c - (c>>2), truncated (255 -> 192).
REQ-019 SHALL produce, when parity=1 and mode_act=2, c>>1 (255 -> 127).
REQ-020 SHALL produce, when parity=1 and mode_act=3, c>>2 (255 -> 63).
REQ-021 SHALL keep all arithmetic in DW bits with no overflow possible; c - (c>>2) never underflows.
REQ-022 SHALL force colour outputs to 0 whenever blank=1 at the sampling pix_ce, regardless of mode.
REQ-023 SHALL give all outputs a latency of exactly one pix_ce: the outputs for inputs sampled at pix_ce n appear after that edge and hold until pix_ce n+1.
REQ-024 SHALL hold all outputs and internal state unchanged on clk edges where pix_ce=0.
REQ-025 SHALL use the parity in effect before the current edge's update to process the pixel sampled on an hs rising edge, so the toggle applies from the next pixel.

Reset
REQ-026 SHALL, while reset=1 on a clk edge, clear every register to 0 irrespective of pix_ce: parity, mode_act, hs_d, vs_d, all colour outputs, hs_out, vs_out and blank_out.
REQ-027 SHALL, after reset is released mid-frame, run with mode_act=0 (pass-through) until the first vs rising edge.
REQ-028 SHALL treat an hs or vs already high at reset release as a rising edge on the first pix_ce, because hs_d and vs_d reset to 0.

Structure
REQ-029 SHALL place a mode enumeration (OFF, D25, D50, D75) in shared package scanline_pkg, for use by scanline_fx and the OSD/config decode.
REQ-030 SHALL implement the per-channel darkening as one function applied identically to the three channels; no sub-module is required.
REQ-031 SHALL contain no memories and no combinational path from any input to any output.

Verification
REQ-032 SHALL pass: mode=2 latched at a vs edge, constant RGB=255,128,0, three lines -> lines 0 and 2 output 255,128,0; line 1 outputs 127,64,0.
REQ-033 SHALL pass: mode changes 2 -> 3 mid-line with no vs edge -> odd lines stay at 50% until the next vs edge, then 255 -> 63.
REQ-034 SHALL pass: hs and vs rise on the same pix_ce -> parity=0, and the next line is undarkened.
REQ-035 SHALL pass: blank=1 with RGB=255,255,255 on an odd line with mode=1 -> outputs 0,0,0 with blank_out=1 one pix_ce later.
REQ-036 SHALL pass: pix_ce held low for 5 clocks mid-line -> all outputs stable for those clocks.
REQ-037 SHALL pass: reset pulsed mid-line during mode=3 -> next clock all outputs 0; subsequent odd lines pass through until the first vs edge.
